// File: rtl/line_fill_memory_if.sv
// Request/response channel between the cache and the line-fill backing memory.
// The cache drives the request side and accepts response beats.
interface line_fill_memory_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                                 reqValid_MEM;
    logic                                 reqReady_MEM;
    logic [ADDR_WIDTH-1:0]                reqAddress_MEM;
    logic                                 reqWen_MEM;
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] reqDataIn_MEM;
    logic                                 respValid_MEM;
    logic                                 respReady_MEM;
    logic [WORD_WIDTH-1:0]                respDataOut_MEM;
    logic                                 respLast_MEM;

    modport master (
        output reqValid_MEM, reqAddress_MEM, reqWen_MEM, reqDataIn_MEM, respReady_MEM,
        input  reqReady_MEM, respValid_MEM, respDataOut_MEM, respLast_MEM
    );

    modport slave (
        input  reqValid_MEM, reqAddress_MEM, reqWen_MEM, reqDataIn_MEM, respReady_MEM,
        output reqReady_MEM, respValid_MEM, respDataOut_MEM, respLast_MEM
    );
endinterface

// File: rtl/line_fill_memory.sv
// Line-granular backing memory behind the cache: fixed-latency line fills as a
// burst of word beats, and whole-line writebacks acknowledged by a single beat.
module line_fill_memory #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int DEPTH_LINES    = 256,
    parameter int LATENCY        = 4
) (
    input  logic              clk,
    input  logic              rst,
    line_fill_memory_if.slave memBus
);
    localparam int OFF    = $clog2(WORDS_PER_LINE * 4);
    localparam int IDX    = $clog2(DEPTH_LINES);
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_t;
    typedef line_t [DEPTH_LINES-1:0]                   mem_t;
    typedef enum logic [1:0] {IDLE, WAIT, READ_BURST, WRITE_ACK} state_t;
    typedef struct packed {
        logic [IDX-1:0] idx;
        logic           wen;
        line_t          data;
    } req_t;

    // Power-up image: each word holds its own byte address.
    function automatic mem_t initMem();
        mem_t m;
        for (int l = 0; l < DEPTH_LINES; l++)
            for (int w = 0; w < WORDS_PER_LINE; w++)
                m[l][w] = WORD_WIDTH'((l * WORDS_PER_LINE + w) * 4);
        return m;
    endfunction

    mem_t             mem = initMem();
    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [BEAT_W-1:0] beat, beatNext;
    req_t             req;
    logic             accept, commit, lastBeat;
    logic             unusedAddrBits;

    assign accept   = memBus.reqValid_MEM && (state == IDLE);
    assign commit   = (state == WAIT) && (cnt == '0) && req.wen;
    assign lastBeat = (beat == BEAT_W'(WORDS_PER_LINE - 1));
    assign unusedAddrBits = ^{memBus.reqAddress_MEM[ADDR_WIDTH-1:OFF+IDX],
                              memBus.reqAddress_MEM[OFF-1:0]};

    always_comb begin
        stateNext               = state;
        cntNext                 = cnt;
        beatNext                = beat;
        memBus.reqReady_MEM     = 1'b0;
        memBus.respValid_MEM    = 1'b0;
        memBus.respLast_MEM     = 1'b0;
        memBus.respDataOut_MEM  = '0;
        unique case (state)
            IDLE: begin
                memBus.reqReady_MEM = 1'b1;
                if (memBus.reqValid_MEM) begin
                    stateNext = WAIT;
                    cntNext   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    stateNext = req.wen ? WRITE_ACK : READ_BURST;
                    beatNext  = '0;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            READ_BURST: begin
                memBus.respValid_MEM   = 1'b1;
                memBus.respLast_MEM    = lastBeat;
                memBus.respDataOut_MEM = mem[req.idx][beat];
                if (memBus.respReady_MEM) begin
                    if (lastBeat) begin
                        stateNext = IDLE;
                        beatNext  = '0;
                    end else begin
                        beatNext = beat + 1'b1;
                    end
                end
            end
            WRITE_ACK: begin
                memBus.respValid_MEM = 1'b1;
                memBus.respLast_MEM  = 1'b1;
                if (memBus.respReady_MEM) stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            beat  <= '0;
            req   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            beat  <= beatNext;
            if (accept)
                req <= '{idx:  memBus.reqAddress_MEM[OFF+IDX-1:OFF],
                         wen:  memBus.reqWen_MEM,
                         data: line_t'(memBus.reqDataIn_MEM)};
        end
    end

    // Storage has no reset; a reset during WAIT leaves state != WAIT so nothing commits.
    always_ff @(posedge clk) begin
        if (commit) mem[req.idx] <= req.data;
    end
endmodule

// File: doc/line_fill_memory.md
Name: line_fill_memory

Overview:
- Backing-memory stage directly downstream of the cache inside the memory system.
- Serves line fills on a cache miss and line writebacks on dirty eviction, using a valid/ready request channel and a burst response channel.
- Models fixed access latency with a countdown counter.
- Line-granular: 16-byte lines of 4 x 32-bit words at default parameters.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, bits per word.
- WORDS_PER_LINE, 4, words per cache line; must be a power of 2, >=2.
- DEPTH_LINES, 256, number of lines stored; must be a power of 2.
- LATENCY, 4, cycles from request acceptance to first response beat; must be >=1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqValid_MEM  in  1  cache presents a request.
- reqReady_MEM  out  1  memory can accept a request this cycle.
- reqAddress_MEM  in  ADDR_WIDTH  byte address; offset bits within the line are ignored.
- reqWen_MEM  in  1  1 = line writeback, 0 = line fill.
- reqDataIn_MEM  in  WORD_WIDTH*WORDS_PER_LINE  writeback line; word i occupies bits [32i+31:32i].
- respValid_MEM  out  1  response beat valid.
- respReady_MEM  in  1  cache accepts the beat.
- respDataOut_MEM  out  WORD_WIDTH  read beat data; 0 on write ack.
- respLast_MEM  out  1  final beat of the response.

Behaviour:
- Storage: DEPTH_LINES x WORDS_PER_LINE words.
  - Initialised at time zero so the word at byte address A holds A (line 1 word 2 = 0x00000018).
  - Contents are NOT cleared by rst.
- Line index = reqAddress_MEM[OFF+IDX-1:OFF], where OFF = log2(WORDS_PER_LINE*4) and IDX = log2(DEPTH_LINES).
  - Higher address bits are ignored, so addresses alias modulo DEPTH_LINES lines.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, beat index=0.
  - reqReady_MEM=1, respValid_MEM=0, respLast_MEM=0, respDataOut_MEM=0.
- FSM states: IDLE, WAIT, READ_BURST, WRITE_ACK.
- IDLE:
  - reqReady_MEM=1.
  - On reqValid_MEM&&reqReady_MEM at edge k: latch address, wen and line data; load counter=LATENCY-1; go to WAIT.
- WAIT:
  - reqReady_MEM=0; counter decrements each cycle.
  - When counter==0 at an edge:
    - read: go to READ_BURST with beat=0.
    - write: commit all words of the latched line in that same edge, then go to WRITE_ACK.
  - The first respValid_MEM is therefore high in the cycle after edge k+LATENCY.
- READ_BURST:
  - respValid_MEM=1; respDataOut_MEM = word[beat], in order word 0, 1, ..., WORDS_PER_LINE-1.
  - respLast_MEM=1 only on the final beat.
  - beat advances only on respValid_MEM&&respReady_MEM; if respReady_MEM=0, data and last hold stable.
  - After the last beat is accepted: go to IDLE with beat=0.
- WRITE_ACK:
  - respValid_MEM=1, respLast_MEM=1, respDataOut_MEM=0.
  - Go to IDLE when respReady_MEM=1.
- Flow control:
  - Only one request is outstanding at a time; no pipelining.
  - reqReady_MEM is 0 in every non-IDLE state.
  - A request held during busy states is accepted on the first IDLE cycle.
  - A request accepted in IDLE is not re-accepted in the same cycle the previous response completes; IDLE is always at least one cycle.
- Read-after-write: a fill to a line written by a completed writeback returns the new data.
- Reset mid-operation: any in-flight request is dropped.
  - A write still in WAIT is not committed.
  - A write already committed, then reset during WRITE_ACK, stays committed.
- Unused reqDataIn_MEM is ignored on reads. reqAddress_MEM offset bits never affect beat order.

Test Plan:
- Reset then read 0x00000000 with respReady_MEM=1 -> 4 consecutive beats 0x0, 0x4, 0x8, 0xC, first beat 4 cycles after acceptance, respLast_MEM only on 0xC, reqReady_MEM low throughout.
- Read 0x00000014 -> beats 0x10, 0x14, 0x18, 0x1C (offset ignored, word 0 first).
- Write 0x00000020 with line {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000} -> single ack beat with last=1 and data 0. Then read 0x20 -> 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003.
- Read 0x30 with respReady_MEM toggling 1,0,0,1,1,0,1 -> beats 0x30..0x3C in order, each held stable while stalled, exactly 4 handshakes.
- Read 0x00001000 (aliases line 0 at DEPTH_LINES=256) -> 0x0, 0x4, 0x8, 0xC.
- Write 0x40 with 0xFFFFFFFF words, rst pulsed low 2 cycles after acceptance -> outputs reset immediately. A following read of 0x40 returns 0x40, 0x44, 0x48, 0x4C (write not committed).
